// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
//   - Opcode constants for IR[31:26]
//   - aluInstruct codes consumed by the ALU control decoder
//   - Main control FSM state encoding (4-bit, FETCH = 0)
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

endpackage

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Sequences fetch / decode / execute / memory / write-back and drives the
// datapath mux selects, write enables and the 2-bit aluInstruct code.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   opcode                IR[31:26], valid from DECODE onward
//   zero                  ALU zero flag (used in BRANCH)
//   memReady              memory access completes in a cycle with memReady=1
//   pcWrite .. pcSource   datapath controls (Moore, except FETCH/BRANCH pcWrite
//                         and FETCH irWrite)
//   illegalOp             registered one-cycle pulse after an unsupported opcode
//   instrCount            retired-instruction counter, wraps
module multi_cycle_control
    import mips_pkg::*;
#(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               memReady,
    output logic               pcWrite,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               irWrite,
    output logic               regDst,
    output logic               memToReg,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         aluInstruct,
    output logic [1:0]         pcSource,
    output logic               illegalOp,
    output logic [COUNT_W-1:0] instrCount
);

    state_t state, next_state;
    logic   illegal_dec;
    logic   retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        illegal_dec = 1'b0;
        unique case (state)
            S_FETCH:  if (memReady) next_state = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default: begin
                        next_state  = S_FETCH;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (memReady) next_state = S_MEMWB;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  if (memReady) next_state = S_FETCH;
            S_EXEC:   next_state = S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_ADDIEX: next_state = S_ADDIWB;
            S_ADDIWB: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pcWrite     = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluInstruct = ALU_ADD;
        pcSource    = 2'b00;
        unique case (state)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
            end
            S_DECODE: aluSrcB = 2'b11;
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEMWB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_EXEC: begin
                aluSrcA     = 1'b1;
                aluInstruct = ALU_FUNCT;
            end
            S_ALUWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluInstruct = ALU_SUB;
                pcSource    = 2'b01;
                pcWrite     = zero;
            end
            S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_ADDIWB: regWrite = 1'b1;
            S_JUMP: begin
                pcSource = 2'b10;
                pcWrite  = 1'b1;
            end
            default: ;
        endcase
        // State sits in FETCH during reset, so enables must be masked here
        // to keep the asynchronous reset free of partial writes/requests.
        if (!rst_n) begin
            pcWrite  = 1'b0;
            irWrite  = 1'b0;
            regWrite = 1'b0;
            memWrite = 1'b0;
            memRead  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegalOp <= 1'b0;
        else        illegalOp <= illegal_dec;
    end

    // Retirement: leaving a final state of a legal instruction toward FETCH.
    assign retire = (next_state == S_FETCH) &&
                    (state inside {S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instrCount <= '0;
        else if (retire) instrCount <= instrCount + COUNT_W'(1);
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control (counter narrowed to 4 bits so the
// wrap is reachable). Control outputs are packed into one 16-bit word:
// [15]pcWrite [14]iorD [13]memRead [12]memWrite [11]irWrite [10]regDst
// [9]memToReg [8]regWrite [7]aluSrcA [6:5]aluSrcB [4:3]aluInstruct
// [2:1]pcSource [0]illegalOp
module tb_multi_cycle_control;

    localparam int unsigned CW = 4;

    // Hand-computed control words per state
    localparam logic [15:0] C_RST    = 16'h0020;
    localparam logic [15:0] C_FWAIT  = 16'h2020;
    localparam logic [15:0] C_FRDY   = 16'hA820;
    localparam logic [15:0] C_DEC    = 16'h0060;
    localparam logic [15:0] C_MEMADR = 16'h00C0;
    localparam logic [15:0] C_MEMRD  = 16'h6000;
    localparam logic [15:0] C_MEMWB  = 16'h0300;
    localparam logic [15:0] C_MEMWR  = 16'h5000;
    localparam logic [15:0] C_EXEC   = 16'h0090;
    localparam logic [15:0] C_ALUWB  = 16'h0500;
    localparam logic [15:0] C_BR_T   = 16'h808A;
    localparam logic [15:0] C_BR_N   = 16'h008A;
    localparam logic [15:0] C_ADDIEX = 16'h00C0;
    localparam logic [15:0] C_ADDIWB = 16'h0100;
    localparam logic [15:0] C_JUMP   = 16'h8004;
    localparam logic [15:0] C_FILL   = 16'hA821;

    localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04,
                           ADDI = 6'h08, J = 6'h02, BAD = 6'h3F;

    logic clk = 1'b0;
    logic rst_n;
    logic [5:0] opcode;
    logic zero, memReady;
    logic pcWrite, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluInstruct, pcSource;
    logic illegalOp;
    logic [CW-1:0] instrCount;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multi_cycle_control #(.COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .memReady(memReady),
        .pcWrite(pcWrite), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
        .irWrite(irWrite), .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluInstruct(aluInstruct),
        .pcSource(pcSource), .illegalOp(illegalOp), .instrCount(instrCount)
    );

    function automatic logic [15:0] ctl_word();
        return {pcWrite, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite,
                aluSrcA, aluSrcB, aluInstruct, pcSource, illegalOp};
    endfunction

    task automatic check(input string name, input logic [15:0] ectl, input logic [CW-1:0] ecnt);
        n_checks++;
        if (ctl_word() !== ectl) begin
            n_fail++;
            $display("FAIL %s ctl: got %h expected %h", name, ctl_word(), ectl);
        end
        n_checks++;
        if (instrCount !== ecnt) begin
            n_fail++;
            $display("FAIL %s cnt: got %0d expected %0d", name, instrCount, ecnt);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check mid-cycle.
    task automatic step(input string name, input logic r, input logic [5:0] op, input logic z,
                        input logic mr, input logic [15:0] ectl, input logic [CW-1:0] ecnt);
        @(negedge clk);
        rst_n = r; opcode = op; zero = z; memReady = mr;
        #1;
        check(name, ectl, ecnt);
    endtask

    task automatic do_jump(input logic [CW-1:0] cnt);
        step("j_fetch",  1'b1, J, 1'b0, 1'b1, C_FRDY, cnt);
        step("j_decode", 1'b1, J, 1'b0, 1'b1, C_DEC,  cnt);
        step("j_jump",   1'b1, J, 1'b0, 1'b1, C_JUMP, cnt);
    endtask

    typedef struct {
        logic          r;
        logic [5:0]    op;
        logic          z;
        logic          mr;
        logic [15:0]   ctl;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vecs [36];
    logic [CW-1:0] c;

    initial begin
        rst_n = 1'b0; opcode = '0; zero = 1'b0; memReady = 1'b1;

        vecs = '{
            '{1'b0, R,    1'b0, 1'b1, C_RST,    4'd0},  // reset held, memReady high
            '{1'b0, R,    1'b0, 1'b1, C_RST,    4'd0},
            '{1'b1, R,    1'b0, 1'b1, C_FRDY,   4'd0},  // add: 4 cycles
            '{1'b1, R,    1'b0, 1'b1, C_DEC,    4'd0},
            '{1'b1, R,    1'b0, 1'b1, C_EXEC,   4'd0},
            '{1'b1, R,    1'b0, 1'b1, C_ALUWB,  4'd0},
            '{1'b1, LW,   1'b0, 1'b1, C_FRDY,   4'd1},  // lw with 3 wait cycles
            '{1'b1, LW,   1'b0, 1'b0, C_DEC,    4'd1},  // memReady ignored here
            '{1'b1, LW,   1'b0, 1'b0, C_MEMADR, 4'd1},
            '{1'b1, LW,   1'b0, 1'b0, C_MEMRD,  4'd1},
            '{1'b1, LW,   1'b0, 1'b0, C_MEMRD,  4'd1},
            '{1'b1, LW,   1'b0, 1'b0, C_MEMRD,  4'd1},
            '{1'b1, LW,   1'b0, 1'b1, C_MEMRD,  4'd1},
            '{1'b1, LW,   1'b0, 1'b1, C_MEMWB,  4'd1},
            '{1'b1, BEQ,  1'b1, 1'b1, C_FRDY,   4'd2},  // beq taken
            '{1'b1, BEQ,  1'b1, 1'b1, C_DEC,    4'd2},
            '{1'b1, BEQ,  1'b1, 1'b1, C_BR_T,   4'd2},
            '{1'b1, BEQ,  1'b0, 1'b1, C_FRDY,   4'd3},  // beq not taken
            '{1'b1, BEQ,  1'b0, 1'b1, C_DEC,    4'd3},
            '{1'b1, BEQ,  1'b0, 1'b1, C_BR_N,   4'd3},
            '{1'b1, BAD,  1'b0, 1'b1, C_FRDY,   4'd4},  // illegal opcode
            '{1'b1, BAD,  1'b0, 1'b1, C_DEC,    4'd4},
            '{1'b1, ADDI, 1'b0, 1'b1, C_FILL,   4'd4},  // illegalOp pulse, addi fetch
            '{1'b1, ADDI, 1'b0, 1'b1, C_DEC,    4'd4},
            '{1'b1, ADDI, 1'b0, 1'b1, C_ADDIEX, 4'd4},
            '{1'b1, ADDI, 1'b0, 1'b1, C_ADDIWB, 4'd4},
            '{1'b1, J,    1'b0, 1'b1, C_FRDY,   4'd5},  // j
            '{1'b1, J,    1'b0, 1'b1, C_DEC,    4'd5},
            '{1'b1, J,    1'b0, 1'b1, C_JUMP,   4'd5},
            '{1'b1, SW,   1'b0, 1'b0, C_FWAIT,  4'd6},  // sw, fetch stalls once
            '{1'b1, SW,   1'b0, 1'b1, C_FRDY,   4'd6},
            '{1'b1, SW,   1'b0, 1'b1, C_DEC,    4'd6},
            '{1'b1, SW,   1'b0, 1'b1, C_MEMADR, 4'd6},
            '{1'b1, SW,   1'b0, 1'b0, C_MEMWR,  4'd6},
            '{1'b1, SW,   1'b0, 1'b1, C_MEMWR,  4'd6},
            '{1'b1, R,    1'b0, 1'b0, C_FWAIT,  4'd7}
        };

        for (int unsigned i = 0; i < 36; i++)
            step($sformatf("vec%0d", i), vecs[i].r, vecs[i].op, vecs[i].z, vecs[i].mr,
                 vecs[i].ctl, vecs[i].cnt);

        // Bring the counter to all-ones.
        c = 4'd7;
        for (int unsigned k = 0; k < 8; k++) begin
            do_jump(c);
            c = c + 4'd1;
        end

        // sw stalled in MEMWR with count at all-ones, then asynchronous reset.
        step("sw2_fetch",  1'b1, SW, 1'b0, 1'b1, C_FRDY,   4'hF);
        step("sw2_decode", 1'b1, SW, 1'b0, 1'b1, C_DEC,    4'hF);
        step("sw2_memadr", 1'b1, SW, 1'b0, 1'b1, C_MEMADR, 4'hF);
        step("sw2_memwr",  1'b1, SW, 1'b0, 1'b0, C_MEMWR,  4'hF);
        #2 rst_n = 1'b0;
        #1 check("async_rst", C_RST, 4'd0);
        step("rst_hold",    1'b0, SW, 1'b0, 1'b1, C_RST,  4'd0);
        step("rst_restart", 1'b1, R,  1'b0, 1'b1, C_FRDY, 4'd0);
        step("rst_decode",  1'b1, R,  1'b0, 1'b1, C_DEC,  4'd0);
        step("rst_exec",    1'b1, R,  1'b0, 1'b1, C_EXEC, 4'd0);
        step("rst_aluwb",   1'b1, R,  1'b0, 1'b1, C_ALUWB, 4'd0);

        // Climb to all-ones again, then the next retirement wraps to zero.
        c = 4'd1;
        for (int unsigned k = 0; k < 14; k++) begin
            do_jump(c);
            c = c + 4'd1;
        end
        do_jump(4'hF);
        step("wrap", 1'b1, R, 1'b0, 1'b0, C_FWAIT, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
